// File: rtl/axis_to_avst_if.sv
// rtl/axis_to_avst_if.sv - AXIS ingress and Avalon-ST egress signal bundle for axis_to_avst
interface axis_to_avst_if #(
    parameter int DWIDTH    = 512,
    parameter int ERR_WIDTH = 6
);
    localparam int KEEP_WIDTH = DWIDTH / 8;
    localparam int EMPTY_MSB  = $clog2(KEEP_WIDTH);

    logic                  axis_tvalid;
    logic                  axis_tready;
    logic [DWIDTH-1:0]     axis_tdata;
    logic [KEEP_WIDTH-1:0] axis_tkeep;
    logic                  axis_tlast;
    logic                  axis_tuser;

    logic                  avst_ready;
    logic                  avst_valid;
    logic                  avst_start;
    logic                  avst_end;
    logic [DWIDTH-1:0]     avst_data;
    logic [EMPTY_MSB-1:0]  avst_empty;
    logic [ERR_WIDTH-1:0]  avst_error;

    // master: the packet source / sink environment around the bridge
    modport master (
        output axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser, avst_ready,
        input  axis_tready, avst_valid, avst_start, avst_end, avst_data, avst_empty, avst_error
    );

    // slave: the bridge itself
    modport slave (
        input  axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser, avst_ready,
        output axis_tready, avst_valid, avst_start, avst_end, avst_data, avst_empty, avst_error
    );
endinterface

// File: rtl/axis_to_avst.sv
// rtl/axis_to_avst.sv - AXIS to Avalon-ST bridge with byte swap, SOP/EOP, empty, error and 2-entry skid
// Optional tkeep legality check enabled by AXIS_TO_AVST_KEEP_CHECK_EN (adds keep_err port, avst_error[1]).
module axis_to_avst #(
    parameter int DWIDTH    = 512,
    parameter int ERR_WIDTH = 6
) (
    input  logic clk,
    input  logic rst_n,
    axis_to_avst_if.slave bus
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
    ,
    output logic keep_err
`endif
);
    localparam int KEEP_WIDTH = DWIDTH / 8;
    localparam int EMPTY_MSB  = $clog2(KEEP_WIDTH);
    localparam int CW         = EMPTY_MSB + 1;
    localparam int BW         = DWIDTH + EMPTY_MSB + 2 + ERR_WIDTH;

    logic [BW-1:0]        main_beat, skid_beat, conv_beat;
    logic                 main_valid, skid_valid, tready_r, in_pkt;
    logic [DWIDTH-1:0]    conv_data;
    logic [CW-1:0]        keep_cnt, empty_full;
    logic [EMPTY_MSB-1:0] conv_empty;
    logic [ERR_WIDTH-1:0] conv_error;
    logic                 accept, out_free, skid_fill, skid_drain;
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
    logic [KEEP_WIDTH-1:0] keep_plus;
    logic                  keep_bad;
`endif

    assign accept     = bus.axis_tvalid & tready_r;
    assign out_free   = ~main_valid | bus.avst_ready;
    assign skid_fill  = accept & ~out_free;
    assign skid_drain = skid_valid & out_free;

    always_comb begin
        conv_data = '0;
        keep_cnt  = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            conv_data[8*i +: 8] = bus.axis_tdata[8*(KEEP_WIDTH-1-i) +: 8];
            keep_cnt            = keep_cnt + CW'(bus.axis_tkeep[i]);
        end
        empty_full = CW'(KEEP_WIDTH) - keep_cnt;
        // an all-zero tkeep is illegal; report it as the emptiest legal beat
        if (keep_cnt == '0) begin
            conv_empty = EMPTY_MSB'(KEEP_WIDTH - 1);
        end else begin
            conv_empty = empty_full[EMPTY_MSB-1:0];
        end
        conv_error    = '0;
        conv_error[0] = bus.axis_tuser & bus.axis_tlast;
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
        keep_plus     = bus.axis_tkeep + KEEP_WIDTH'(1);
        keep_bad      = (bus.axis_tkeep == '0)
                      | ((bus.axis_tkeep & keep_plus) != '0)
                      | (~bus.axis_tlast & ~(&bus.axis_tkeep));
        conv_error[1] = keep_bad;
`endif
        conv_beat = {conv_data, conv_empty, ~in_pkt, bus.axis_tlast, conv_error};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_beat  <= '0;
            skid_beat  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            tready_r   <= 1'b0;
            in_pkt     <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    main_beat  <= skid_beat;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= accept;
                    if (accept) begin
                        main_beat <= conv_beat;
                    end
                end
            end else if (accept) begin
                skid_beat  <= conv_beat;
                skid_valid <= 1'b1;
            end
            if (accept) begin
                in_pkt <= ~bus.axis_tlast;
            end
            tready_r <= ~((skid_valid & ~skid_drain) | skid_fill);
        end
    end

`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_err <= 1'b0;
        end else if (accept & keep_bad) begin
            keep_err <= 1'b1;
        end
    end
`endif

    assign bus.axis_tready = tready_r;
    assign bus.avst_valid  = main_valid;
    assign {bus.avst_data, bus.avst_empty, bus.avst_start, bus.avst_end, bus.avst_error} = main_beat;
endmodule

// File: tb/tb_axis_to_avst.sv
// tb/tb_axis_to_avst.sv - randomized self-checking bench for axis_to_avst against a queue model
module tb_axis_to_avst;
    localparam int DW = 512;
    localparam int EW = 6;
    localparam int K  = DW / 8;
    localparam int EM = $clog2(K);

    typedef struct {
        logic [DW-1:0] data;
        logic [EM-1:0] empty;
        logic          start;
        logic          eop;
        logic [EW-1:0] err;
        int            cyc;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_to_avst_if #(.DWIDTH(DW), .ERR_WIDTH(EW)) bus ();
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
    logic keep_err;
`endif

    axis_to_avst #(.DWIDTH(DW), .ERR_WIDTH(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
        ,
        .keep_err (keep_err)
`endif
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t expq[$];
    beat_t logq[$];
    bit    m_in_pkt;
    bit    m_keep_err;
    bit    prev_stall;
    beat_t prev;
    int    edges;
    int    cyc = 0;
    int    ready_mode = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t convert(input logic [DW-1:0] d, input logic [K-1:0] k,
                                      input logic last, input logic user, input bit in_pkt);
        beat_t b;
        int    cnt = 0;
        for (int i = 0; i < K; i++) begin
            b.data[8*i +: 8] = d[8*(K-1-i) +: 8];
            cnt += int'(k[i]);
        end
        b.empty  = (cnt == 0) ? EM'(K - 1) : EM'(K - cnt);
        b.start  = !in_pkt;
        b.eop    = last;
        b.err    = '0;
        b.err[0] = user & last;
        b.cyc    = 0;
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
        begin
            bit seen_zero = 0;
            bit bad = 0;
            for (int i = 0; i < K; i++) begin
                if (!k[i]) seen_zero = 1;
                else if (seen_zero) bad = 1;
            end
            if (cnt == 0) bad = 1;
            if (!last && cnt != K) bad = 1;
            b.err[1] = bad;
        end
`endif
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // reference model and per-cycle comparison, sampled mid-cycle
    always @(negedge clk) begin
        beat_t cur, b;
        bit    acc, drn;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            m_in_pkt   = 0;
            m_keep_err = 0;
            prev_stall = 0;
        end else begin
            cur.data  = bus.avst_data;
            cur.empty = bus.avst_empty;
            cur.start = bus.avst_start;
            cur.eop   = bus.avst_end;
            cur.err   = bus.avst_error;
            cur.cyc   = cyc;
            chk("avst_valid", bus.avst_valid, expq.size() > 0);
            chk("axis_tready", bus.axis_tready, (edges > 0) && (expq.size() < 2));
            if (bus.avst_valid && expq.size() > 0) begin
                chk("data_order", cur.data, expq[0].data);
                chk("empty", cur.empty, expq[0].empty);
                chk("start", cur.start, expq[0].start);
                chk("end", cur.eop, expq[0].eop);
                chk("error", cur.err, expq[0].err);
            end
            if (prev_stall) begin
                chk("stall_data", cur.data, prev.data);
                chk("stall_ctl", {cur.empty, cur.start, cur.eop, cur.err},
                                 {prev.empty, prev.start, prev.eop, prev.err});
            end
`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
            chk("keep_err_model", keep_err, m_keep_err);
`endif
            acc = bus.axis_tvalid & bus.axis_tready;
            drn = bus.avst_valid & bus.avst_ready;
            if (drn) begin
                logq.push_back(cur);
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (acc) begin
                b = convert(bus.axis_tdata, bus.axis_tkeep, bus.axis_tlast, bus.axis_tuser, m_in_pkt);
                expq.push_back(b);
                m_in_pkt   = !bus.axis_tlast;
                m_keep_err = m_keep_err | b.err[1];
            end
            prev_stall = bus.avst_valid & !bus.avst_ready;
            prev       = cur;
        end
    end

    initial begin
        bit [3:0] pat = 4'b1001;
        int phase = 0;
        bus.avst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.avst_ready = 1'b1;
                1:       begin bus.avst_ready = pat[phase % 4]; phase++; end
                default: bus.avst_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [K-1:0] k, input logic l, input logic u);
        int n = 0;
        bus.axis_tvalid = 1'b1;
        bus.axis_tdata  = d;
        bus.axis_tkeep  = k;
        bus.axis_tlast  = l;
        bus.axis_tuser  = u;
        @(negedge clk);
        while (!bus.axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", bus.axis_tready, 1'b1);
        @(posedge clk);
        #1;
        bus.axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [K-1:0]  ones;
        logic [K-1:0]  kk;
        int            base, len;
        ones            = '1;
        bus.axis_tvalid = 1'b0;
        bus.axis_tdata  = '0;
        bus.axis_tkeep  = '0;
        bus.axis_tlast  = 1'b0;
        bus.axis_tuser  = 1'b0;

        #12;
        chk("rst_valid", bus.avst_valid, 1'b0);
        chk("rst_tready", bus.axis_tready, 1'b0);
        chk("rst_outs", {bus.avst_start, bus.avst_end, bus.avst_empty, bus.avst_error}, '0);
        chk("rst_data", bus.avst_data, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk("tready_before_edge", bus.axis_tready, 1'b0);
        @(posedge clk);
        #1;
        chk("tready_first_edge", bus.axis_tready, 1'b1);

        // single beat, 8 bytes kept
        d = rand_data();
        d[7:0] = 8'hA5;
        send(d, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
        chk("t1_valid", bus.avst_valid, 1'b1);
        chk("t1_sop_eop", {bus.avst_start, bus.avst_end}, 2'b11);
        chk("t1_empty", bus.avst_empty, 6'd56);
        chk("t1_error", bus.avst_error, 6'd0);
        chk("t1_msb_byte", bus.avst_data[511:504], 8'hA5);
        idle(3);

        // 3-beat packet then a 2-beat packet, back to back
        base = logq.size();
        send(rand_data(), ones, 1'b0, 1'b0);
        send(rand_data(), ones, 1'b0, 1'b0);
        send(rand_data(), 64'h0F, 1'b1, 1'b0);
        send(rand_data(), ones, 1'b0, 1'b0);
        send(rand_data(), ones, 1'b1, 1'b0);
        idle(4);
        chk("t2_count", logq.size() - base, 5);
        if (logq.size() - base >= 5) begin
            chk("t2_starts", {logq[base].start, logq[base+1].start, logq[base+2].start,
                              logq[base+3].start, logq[base+4].start}, 5'b10010);
            chk("t2_ends", {logq[base].eop, logq[base+1].eop, logq[base+2].eop,
                            logq[base+3].eop, logq[base+4].eop}, 5'b00101);
            chk("t2_empties", {logq[base].empty, logq[base+1].empty, logq[base+2].empty},
                              {6'd0, 6'd0, 6'd60});
            chk("t2_no_bubble", logq[base+4].cyc - logq[base].cyc, 4);
        end

        // tuser on both beats: only the tlast beat carries error
        base = logq.size();
        send(rand_data(), ones, 1'b0, 1'b1);
        send(rand_data(), ones, 1'b1, 1'b1);
        idle(3);
        chk("t3_count", logq.size() - base, 2);
        if (logq.size() - base >= 2) begin
            chk("t3_err0", logq[base].err, 6'b000000);
            chk("t3_err1", logq[base+1].err, 6'b000001);
        end

        // backpressure pattern 1,0,0,1
        ready_mode = 1;
        base = logq.size();
        for (int i = 0; i < 10; i++) begin
            d = rand_data();
            d[7:0] = 8'(i);
            send(d, ones, 1'b1, 1'b0);
        end
        idle(30);
        chk("t4_count", logq.size() - base, 10);
        if (logq.size() - base >= 10) begin
            for (int i = 0; i < 10; i++) chk("t4_order", logq[base+i].data[511:504], 8'(i));
        end

        // randomized packets with random backpressure
        ready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                if (b == len - 1) kk = ones >> $urandom_range(0, K);
                else              kk = ones;
                send(rand_data(), kk, b == len - 1, 1'($urandom_range(0, 1)));
            end
        end
        ready_mode = 0;
        idle(10);
        chk("t5_drained", expq.size(), 0);

        // reset in the middle of a packet
        send(rand_data(), ones, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", bus.avst_valid, 1'b0);
        chk("t6_async_outs", {bus.axis_tready, bus.avst_start, bus.avst_end, bus.avst_empty,
                              bus.avst_error}, '0);
        chk("t6_async_data", bus.avst_data, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        base = logq.size();
        send(rand_data(), ones, 1'b0, 1'b0);
        idle(3);
        chk("t6_count", logq.size() - base, 1);
        if (logq.size() > base) chk("t6_start", logq[base].start, 1'b1);

`ifdef AXIS_TO_AVST_KEEP_CHECK_EN
        send(rand_data(), ones, 1'b1, 1'b0);
        idle(2);
        base = logq.size();
        send(rand_data(), 64'h0000_0000_0000_00F0, 1'b1, 1'b0);
        idle(2);
        chk("t7_count", logq.size() - base, 1);
        if (logq.size() > base) chk("t7_err1", logq[base].err[1], 1'b1);
        chk("t7_keep_err", keep_err, 1'b1);
        send(rand_data(), ones, 1'b1, 1'b0);
        idle(3);
        chk("t7_keep_err_sticky", keep_err, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_keep_err_rst", keep_err, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
